// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// Radix-4 recoding is selected by defining BOOTH_RADIX4_EN; otherwise radix-2.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } booth_state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD1 = 3'd1,
    OP_SUB1 = 3'd2,
    OP_ADD2 = 3'd3,
    OP_SUB2 = 3'd4
  } booth_op_e;

`ifdef BOOTH_RADIX4_EN
  localparam bit BOOTH_RADIX4 = 1'b1;
`else
  localparam bit BOOTH_RADIX4 = 1'b0;
`endif

  localparam int BOOTH_SHIFT = BOOTH_RADIX4 ? 2 : 1;

  // Number of recoding steps (CALC cycles) for a given multiplier width.
  function automatic int booth_num_steps(input int width_q, input bit radix4);
    if (radix4) begin
      return (width_q + 1) / 2;
    end else begin
      return width_q;
    end
  endfunction

  // Radix-4 walks two bits per step, so the multiplier register is padded to an even width.
  function automatic int booth_qr_width(input int width_q, input bit radix4);
    if (radix4) begin
      return width_q + (width_q % 2);
    end else begin
      return width_q;
    end
  endfunction

  // Guard bits: one covers -M of the most-negative multiplicand, two cover +/-2M.
  function automatic int booth_ac_width(input int width_m, input bit radix4);
    if (radix4) begin
      return width_m + 2;
    end else begin
      return width_m + 1;
    end
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth recoding step: decode, add/subtract, arithmetic shift.
// Decodes {QR[1:0],Q-1} when BOOTH_RADIX4_EN is defined, else {QR[0],Q-1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH_M = 8,
  parameter int WIDTH_Q = 8,
  localparam int ACW = booth_ac_width(WIDTH_M, BOOTH_RADIX4),
  localparam int QW  = booth_qr_width(WIDTH_Q, BOOTH_RADIX4)
) (
  input  logic signed [ACW-1:0] ac_i,
  input  logic        [QW-1:0]  qr_i,
  input  logic                  qm1_i,
  input  logic signed [ACW-1:0] m_i,
  output logic signed [ACW-1:0] ac_o,
  output logic        [QW-1:0]  qr_o,
  output logic                  qm1_o
);

  booth_op_e               op_s;
  logic signed [ACW-1:0]   m2_s;
  logic signed [ACW-1:0]   sum_s;
  logic signed [ACW+QW:0]  cat_s;
  logic signed [ACW+QW:0]  shf_s;

  assign m2_s = {m_i[ACW-2:0], 1'b0};

  // Recode the inspected multiplier bits into an operation.
  always_comb begin
    op_s = OP_NOP;
`ifdef BOOTH_RADIX4_EN
    case ({qr_i[1:0], qm1_i})
      3'b001, 3'b010: op_s = OP_ADD1;
      3'b011:         op_s = OP_ADD2;
      3'b100:         op_s = OP_SUB2;
      3'b101, 3'b110: op_s = OP_SUB1;
      default:        op_s = OP_NOP;
    endcase
`else
    case ({qr_i[0], qm1_i})
      2'b01:   op_s = OP_ADD1;
      2'b10:   op_s = OP_SUB1;
      default: op_s = OP_NOP;
    endcase
`endif
  end

  // Apply the recoded operation to the accumulator, then shift {AC,QR,Q-1} arithmetically.
  always_comb begin
    sum_s = ac_i;
    case (op_s)
      OP_ADD1: sum_s = ac_i + m_i;
      OP_SUB1: sum_s = ac_i - m_i;
      OP_ADD2: sum_s = ac_i + m2_s;
      OP_SUB2: sum_s = ac_i - m2_s;
      default: sum_s = ac_i;
    endcase
    cat_s = {sum_s, qr_i, qm1_i};
    shf_s = cat_s >>> BOOTH_SHIFT;
  end

  assign ac_o  = shf_s[ACW+QW:QW+1];
  assign qr_o  = shf_s[QW:1];
  assign qm1_o = shf_s[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed Booth multiplier with start/busy/done handshake.
// Define BOOTH_RADIX4_EN for radix-4 recoding (fewer CALC cycles, same product).
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH_M = 8,
  parameter int WIDTH_Q = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH_M-1:0]         multiplicand,
  input  logic [WIDTH_Q-1:0]         multiplier,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH_M+WIDTH_Q-1:0] product
);

  localparam int ACW = booth_ac_width(WIDTH_M, BOOTH_RADIX4);
  localparam int QW  = booth_qr_width(WIDTH_Q, BOOTH_RADIX4);
  localparam int N   = booth_num_steps(WIDTH_Q, BOOTH_RADIX4);
  localparam int CW  = $clog2(N + 1);
  localparam int PW  = WIDTH_M + WIDTH_Q;

  booth_state_e          state_q, state_d;
  logic signed [ACW-1:0] ac_q, ac_d;
  logic        [QW-1:0]  qr_q, qr_d;
  logic                  qm1_q, qm1_d;
  logic signed [ACW-1:0] m_q, m_d;
  logic        [CW-1:0]  count_q, count_d;
  logic        [PW-1:0]  product_q, product_d;
  logic                  busy_q, done_q;

  logic signed [ACW-1:0] ac_step_s;
  logic        [QW-1:0]  qr_step_s;
  logic                  qm1_step_s;
  logic     [ACW+QW-1:0] prod_full_s;

  booth_step #(
    .WIDTH_M (WIDTH_M),
    .WIDTH_Q (WIDTH_Q)
  ) u_step (
    .ac_i  (ac_q),
    .qr_i  (qr_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .ac_o  (ac_step_s),
    .qr_o  (qr_step_s),
    .qm1_o (qm1_step_s)
  );

  assign prod_full_s = {ac_step_s, qr_step_s};

  // FSM and datapath next-state; product only changes on the last CALC step.
  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    qr_d      = qr_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          ac_d    = {ACW{1'b0}};
          qr_d    = QW'($signed(multiplier));
          qm1_d   = 1'b0;
          m_d     = ACW'($signed(multiplicand));
          count_d = CW'(N);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        ac_d    = ac_step_s;
        qr_d    = qr_step_s;
        qm1_d   = qm1_step_s;
        count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        if (count_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d   = ST_DONE;
          product_d = prod_full_s[PW-1:0];
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ac_q      <= {ACW{1'b0}};
      qr_q      <= {QW{1'b0}};
      qm1_q     <= 1'b0;
      m_q       <= {ACW{1'b0}};
      count_q   <= {CW{1'b0}};
      product_q <= {PW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ac_q      <= ac_d;
      qr_q      <= qr_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
